alu6_sequencer: RTL and testbench

ALU6_SEQUENCER -- requirements
Module: alu6_sequencer

---
 rtl/alu6_sequencer_if.sv | 33 +++
 rtl/alu6_sequencer.sv | 81 ++++++++
 tb/tb_alu6_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu6_sequencer_if.sv
// Command, result and downstream ALU signals of the 6-bit ALU sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface alu6_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_a;
    logic [5:0] cmd_b;
    logic [5:0] alu_a;
    logic [5:0] alu_b;
    logic       alu_carry_in;
    logic       alu_key;
    logic [5:0] alu_result;
    logic       alu_equal;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_data;
    logic       res_eq;
    logic       res_ovf;
    logic [5:0] acc;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_equal, res_ready,
        output cmd_ready, alu_a, alu_b, alu_carry_in, alu_key,
               res_valid, res_data, res_eq, res_ovf, acc
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_equal, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_carry_in, alu_key,
               res_valid, res_data, res_eq, res_ovf, acc
    );
endinterface

// File: rtl/alu6_sequencer.sv
// Three-state sequencer driving an external 6-bit add/sub/compare unit:
// loads operands, captures one result per command and holds it until consumed.
module alu6_sequencer #(
    parameter logic [5:0] ACC_INIT = 6'b000000
) (
    input  logic             clk,
    input  logic             rst_n,
    alu6_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_CMP = 2'b10, OP_ACC = 2'b11} op_t;

    state_t state;
    op_t    op_q;
    op_t    cmd_op_e;
    logic   ovf;

    assign cmd_op_e = op_t'(bus.cmd_op);

    // Overflow judged on the raw operands; SUB compares against the uninverted B
    always_comb begin
        ovf = 1'b0;
        case (op_q)
            OP_ADD, OP_ACC: ovf = (bus.alu_a[5] == bus.alu_b[5]) && (bus.alu_result[5] != bus.alu_a[5]);
            OP_SUB:         ovf = (bus.alu_a[5] != bus.alu_b[5]) && (bus.alu_result[5] != bus.alu_a[5]);
            default:        ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            op_q             <= OP_ADD;
            bus.cmd_ready    <= 1'b1;
            bus.res_valid    <= 1'b0;
            bus.res_data     <= '0;
            bus.res_eq       <= 1'b0;
            bus.res_ovf      <= 1'b0;
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.alu_carry_in <= 1'b0;
            bus.alu_key      <= 1'b0;
            bus.acc          <= ACC_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q             <= cmd_op_e;
                        bus.alu_a        <= (cmd_op_e == OP_ACC) ? bus.acc : bus.cmd_a;
                        bus.alu_b        <= bus.cmd_b;
                        bus.alu_carry_in <= (cmd_op_e == OP_SUB);
                        bus.alu_key      <= (cmd_op_e == OP_CMP);
                        bus.cmd_ready    <= 1'b0;
                        state            <= EXEC;
                    end
                end
                EXEC: begin
                    bus.res_data  <= bus.alu_result;
                    bus.res_eq    <= bus.alu_equal;
                    bus.res_ovf   <= ovf;
                    if (op_q == OP_ACC)
                        bus.acc <= bus.alu_result;
                    bus.res_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.res_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu6_sequencer.sv
// Scoreboard bench for alu6_sequencer with a behavioural ALU unit and arithmetic reference model.
module tb_alu6_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu6_sequencer_if bus();

    alu6_sequencer #(.ACC_INIT(6'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Downstream unit: add, or subtract as A + ~B + 1, or compare result {0,equal}
    assign bus.alu_equal  = (bus.alu_a == bus.alu_b);
    assign bus.alu_result = bus.alu_key ? {5'b0, bus.alu_equal}
                          : bus.alu_a + (bus.alu_carry_in ? ~bus.alu_b : bus.alu_b) + {5'b0, bus.alu_carry_in};

    typedef struct {
        int data;
        int eq;
        int ovf;
        int ci;
        int key;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   acc_model = 0;
    bit   rand_rr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= 32) ? v - 64 : v;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_res_data"}, 32'(bus.res_data), 0);
        chk({tag, "_res_eq"}, 32'(bus.res_eq), 0);
        chk({tag, "_res_ovf"}, 32'(bus.res_ovf), 0);
        chk({tag, "_alu_a"}, 32'(bus.alu_a), 0);
        chk({tag, "_alu_b"}, 32'(bus.alu_b), 0);
        chk({tag, "_alu_carry_in"}, 32'(bus.alu_carry_in), 0);
        chk({tag, "_alu_key"}, 32'(bus.alu_key), 0);
        chk({tag, "_acc"}, 32'(bus.acc), 0);
    endtask

    // Called at posedge+1; returns at posedge+1 once the result is in HOLD.
    task automatic send(input int op, input int a, input int b);
        bit   rdy;
        int   cyc;
        int   opa;
        int   s;
        exp_t e;
        bus.cmd_op    = 2'(op);
        bus.cmd_a     = 6'(a);
        bus.cmd_b     = 6'(b);
        bus.cmd_valid = 1'b1;
        rdy = 1'b0;
        cyc = 0;
        while (!rdy && cyc < 50) begin
            @(negedge clk);
            rdy = bus.cmd_ready;
            @(posedge clk);
            cyc++;
        end
        #1;
        if (!rdy) begin
            chk("accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        opa = (op == 3) ? acc_model : a;
        s   = 0;
        case (op)
            1:       begin s = sgn(opa) - sgn(b); e.data = (opa - b + 64) % 64; end
            2:       begin e.data = (opa == b) ? 1 : 0; end
            default: begin s = sgn(opa) + sgn(b); e.data = (opa + b) % 64; end
        endcase
        e.eq  = (opa == b) ? 1 : 0;
        e.ovf = (op != 2 && (s > 31 || s < -32)) ? 1 : 0;
        e.ci  = (op == 1) ? 1 : 0;
        e.key = (op == 2) ? 1 : 0;
        if (op == 3)
            acc_model = e.data;
        e.acc = acc_model;
        exp_q.push_back(e);
        // Scramble command inputs after acceptance; they must have no effect
        bus.cmd_a     = 6'($urandom);
        bus.cmd_b     = 6'($urandom);
        bus.cmd_op    = 2'($urandom);
        bus.cmd_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("exec_res_valid", 32'(bus.res_valid), 0);
        chk("exec_cmd_ready", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        chk("latency_res_valid", 32'(bus.res_valid), 1);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the held result each cycle, pop when the consumer takes it
    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(bus.res_valid), 0);
            end else begin
                chk("res_data", 32'(bus.res_data), 32'(exp_q[0].data));
                chk("res_eq", 32'(bus.res_eq), 32'(exp_q[0].eq));
                chk("res_ovf", 32'(bus.res_ovf), 32'(exp_q[0].ovf));
                chk("acc", 32'(bus.acc), 32'(exp_q[0].acc));
                chk("alu_carry_in", 32'(bus.alu_carry_in), 32'(exp_q[0].ci));
                chk("alu_key", 32'(bus.alu_key), 32'(exp_q[0].key));
                chk("hold_cmd_ready", 32'(bus.cmd_ready), 0);
                if (bus.res_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rr)
                bus.res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("init");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_cmd_ready", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;

        send(0, 6'b000001, 6'b000001);
        send(1, 6'b111111, 6'b000001);
        send(1, 6'b100000, 6'b000001);
        send(2, 6'b000101, 6'b000101);
        send(2, 6'b000101, 6'b000110);
        send(3, 0, 6'b011111);
        send(3, 0, 6'b000001);
        send(3, 0, 6'b100000);
        drain();

        rand_rr = 1'b1;
        repeat (150)
            send($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 63));
        rand_rr = 1'b0;
        bus.res_ready = 1'b1;
        drain();

        bus.res_ready = 1'b0;
        send(0, 6'd10, 6'd20);
        repeat (5) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = 6'($urandom);
            @(posedge clk);
            #1;
        end
        chk("bp_res_valid", 32'(bus.res_valid), 1);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("bp_idle_res_valid", 32'(bus.res_valid), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_no_queued_cmd", 32'(bus.res_valid), 0);
        end
        chk("bp_queue_empty", 32'(exp_q.size()), 0);

        bus.res_ready = 1'b0;
        send(3, 0, 6'd7);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("midhold");
        exp_q.delete();
        acc_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        send(3, 0, 6'd5);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
